// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared defaults, debounce length helper and key index constants for the timer front end
package timer_pkg;

    localparam int CLK_HZ_DEFAULT      = 50_000_000;
    localparam int TICK_HZ_DEFAULT     = 1;
    localparam int DEBOUNCE_MS_DEFAULT = 20;

    localparam int KEY_CLEAR = 0;
    localparam int KEY_RUN   = 1;

    function automatic int db_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/timer_control_if.sv
// rtl/timer_control_if.sv - key inputs and timer-counter control outputs of the timer front end
interface timer_control_if;

    logic [1:0] key_n;
    logic       clk_1hz;
    logic       tick_1hz;
    logic       run;
    logic       clear;

    modport master (
        output key_n,
        input  clk_1hz,
        input  tick_1hz,
        input  run,
        input  clear
    );

    modport slave (
        input  key_n,
        output clk_1hz,
        output tick_1hz,
        output run,
        output clear
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser, debouncer and registered press pulse for one active-low key
module key_debounce #(
    parameter int DB_CYCLES = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == LAST) begin
                    // stable=1 here means the key is going down: that is the press event
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= stable;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/timer_control.sv
// rtl/timer_control.sv - key conditioning, 1 Hz divider, run toggle and clear pulse; option TIMER_TICK_ALIGN_EN
module timer_control
    import timer_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int TICK_HZ     = TICK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
    input  logic            clk_50mhz,
    input  logic            reset,
    timer_control_if.slave  bus
);

    localparam int HALF = CLK_HZ / (2 * TICK_HZ);
    localparam int DB   = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int DW   = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

    logic [1:0]    press;
    logic [DW-1:0] div;
    logic          clk_q;
    logic          tick_q;
    logic          run_q;
    logic          clear_q;
    logic          wrap;

    key_debounce #(.DB_CYCLES(DB)) u_key_clear (
        .clk   (clk_50mhz),
        .reset (reset),
        .key_n (bus.key_n[KEY_CLEAR]),
        .press (press[KEY_CLEAR])
    );

    key_debounce #(.DB_CYCLES(DB)) u_key_run (
        .clk   (clk_50mhz),
        .reset (reset),
        .key_n (bus.key_n[KEY_RUN]),
        .press (press[KEY_RUN])
    );

    assign wrap = (div == DIV_LAST);

`ifdef TIMER_TICK_ALIGN_EN
    // skip swallows the first wrap after a restart so the first rising edge lands a full period later
    logic skip;
    logic align;

    assign align = (press[KEY_RUN] && !run_q) || press[KEY_CLEAR];

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            div    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            skip   <= 1'b0;
        end else if (align) begin
            div    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            skip   <= 1'b1;
        end else if (wrap) begin
            div    <= '0;
            if (skip) begin
                skip   <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                clk_q  <= ~clk_q;
                tick_q <= ~clk_q;
            end
        end else begin
            div    <= div + 1'b1;
            tick_q <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            div    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (wrap) begin
            div    <= '0;
            clk_q  <= ~clk_q;
            tick_q <= ~clk_q;
        end else begin
            div    <= div + 1'b1;
            tick_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            run_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            run_q   <= run_q ^ press[KEY_RUN];
            clear_q <= press[KEY_CLEAR];
        end
    end

    assign bus.clk_1hz  = clk_q;
    assign bus.tick_1hz = tick_q;
    assign bus.run      = run_q;
    assign bus.clear    = clear_q;

endmodule

// File: tb/tb_timer_control.sv
// tb/tb_timer_control.sv - randomized bench for timer_control against an edge-count/run-length reference model
module tb_timer_control;

    localparam int HALF = 500;
    localparam int DB   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   model_live = 1'b0;

    timer_control_if bus ();

    timer_control #(.CLK_HZ(1000), .TICK_HZ(1), .DEBOUNCE_MS(5)) dut (
        .clk_50mhz (clk),
        .reset     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // reference state: raw samples of the last two edges, mismatch run length, edges since divider restart
    bit mhist[2][2];
    bit mstable[2];
    int mrun_len[2];
    bit mpress[2];
    bit mrun, mclear, mclk, mtick, maligned;
    int medges;

    task automatic step_model(input bit r, input bit [1:0] k);
        bit synced;
        bit prev_run;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                mhist[i][0] = 1'b1; mhist[i][1] = 1'b1;
                mstable[i] = 1'b1; mrun_len[i] = 0; mpress[i] = 1'b0;
            end
            mrun = 0; mclear = 0; mclk = 0; mtick = 0; maligned = 0; medges = 0;
            return;
        end
        prev_run = mrun;
        mclear = mpress[0];
        if (mpress[1]) mrun = !mrun;
        for (int i = 0; i < 2; i++) begin
            synced = mhist[i][0];
            mhist[i][0] = mhist[i][1];
            mhist[i][1] = k[i];
            mpress[i] = 1'b0;
            if (synced != mstable[i]) begin
                mrun_len[i]++;
                if (mrun_len[i] == DB) begin
                    mpress[i] = (synced == 1'b0);
                    mstable[i] = synced;
                    mrun_len[i] = 0;
                end
            end else begin
                mrun_len[i] = 0;
            end
        end
        medges++;
`ifdef TIMER_TICK_ALIGN_EN
        if ((mrun && !prev_run) || mclear) begin
            medges = 0;
            maligned = 1'b1;
        end
`endif
        if (maligned) begin
            mclk  = (medges < 2*HALF) ? 1'b0 : 1'((medges / HALF + 1) % 2);
            mtick = (medges >= 2*HALF) && (medges % (2*HALF) == 0);
        end else begin
            mclk  = 1'((medges / HALF) % 2);
            mtick = (medges % (2*HALF) == HALF);
        end
    endtask

    task automatic check(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0b expected=%0b at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            check("clk_1hz", bus.clk_1hz, mclk);
            check("tick_1hz", bus.tick_1hz, mtick);
            check("run", bus.run, mrun);
            check("clear", bus.clear, mclear);
        end
    end

    // applies inputs for the next rising edge and returns just after the following falling edge
    task automatic cyc(input bit r, input bit [1:0] k);
        rst = r;
        bus.key_n = k;
        step_model(r, k);
        model_live = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b11);
    endtask

    initial begin
        bus.key_n = 2'b11;

        // reset and free-running divider phase
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b11);
        check("reset_clk", bus.clk_1hz, 1'b0);
        check("reset_run", bus.run, 1'b0);
        check("reset_clear", bus.clear, 1'b0);
        for (int i = 1; i <= 1500; i++) begin
            cyc(1'b0, 2'b11);
            if (i == 499) check("lit_clk_499", bus.clk_1hz, 1'b0);
            if (i == 500) check("lit_tick_500", bus.tick_1hz, 1'b1);
            if (i == 501) check("lit_tick_501", bus.tick_1hz, 1'b0);
            if (i == 1000) check("lit_clk_fall_1000", bus.clk_1hz, 1'b0);
            if (i == 1500) check("lit_tick_1500", bus.tick_1hz, 1'b1);
        end

        // short glitch ignored, long press toggles run once at +8
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01);
        idle(20);
        check("lit_glitch_run", bus.run, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 2'b01);
            if (i == 7) check("lit_run_at7", bus.run, 1'b0);
            if (i == 8) check("lit_run_at8", bus.run, 1'b1);
        end
        idle(20);
        check("lit_run_held", bus.run, 1'b1);

        // two clear presses while running
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 20; i++) begin
                cyc(1'b0, 2'b10);
                if (i == 8) check("lit_clear_at8", bus.clear, 1'b1);
                if (i == 9) check("lit_clear_at9", bus.clear, 1'b0);
            end
            check("lit_run_kept", bus.run, 1'b1);
            idle(20);
        end

        // both keys in the same cycle
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 2'b00);
            if (i == 8) begin
                check("lit_both_clear", bus.clear, 1'b1);
                check("lit_both_run", bus.run, 1'b0);
            end
        end
        idle(20);

        // reset mid-debounce, then mid-period
        for (int i = 0; i < 5; i++) cyc(1'b0, 2'b01);
        cyc(1'b1, 2'b11);
        idle(20);
        check("lit_no_press_after_reset", bus.run, 1'b0);
        idle(250);
        cyc(1'b1, 2'b11);
        for (int i = 1; i <= 500; i++) begin
            cyc(1'b0, 2'b11);
            if (i == 499) check("lit_midperiod_499", bus.tick_1hz, 1'b0);
            if (i == 500) check("lit_midperiod_500", bus.tick_1hz, 1'b1);
        end

        // run switched on with the divider at 317
        cyc(1'b1, 2'b11);
        for (int i = 1; i <= 1320; i++) begin
            cyc(1'b0, (i >= 310 && i < 330) ? 2'b01 : 2'b11);
            if (i == 317) check("lit_run_on_317", bus.run, 1'b1);
`ifdef TIMER_TICK_ALIGN_EN
            if (i == 500) check("lit_align_no_tick_500", bus.tick_1hz, 1'b0);
            if (i == 1316) check("lit_align_tick_1316", bus.tick_1hz, 1'b0);
            if (i == 1317) check("lit_align_tick_1317", bus.tick_1hz, 1'b1);
`else
            if (i == 500) check("lit_free_tick_500", bus.tick_1hz, 1'b1);
            if (i == 1317) check("lit_free_no_tick_1317", bus.tick_1hz, 1'b0);
`endif
        end

        // randomized key activity and resets
        for (int chunk = 0; chunk < 400; chunk++) begin
            int mode;
            int len;
            bit [1:0] k;
            mode = $urandom_range(0, 9);
            k = 2'($urandom_range(0, 2));
            if (mode == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) cyc(1'b1, 2'($urandom_range(0, 3)));
            end else if (mode <= 3) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) cyc(1'b0, k);
            end else if (mode <= 6) begin
                len = $urandom_range(5, 60);
                for (int i = 0; i < len; i++) cyc(1'b0, k);
            end else begin
                len = $urandom_range(1, 80);
                idle(len);
            end
        end
        idle(20);

        model_live = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
